// File: rtl/axi_xbar_pkg.sv
// Shared types and default widths for the crossbar write path.
// W_LEN_CHECK_EN adds the burst length to each order FIFO entry.
package axi_xbar_pkg;

   localparam int unsigned DEF_MST_NUM    = 4;
   localparam int unsigned DEF_AXI_ADDR_W = 32;
   localparam int unsigned DEF_AXI_ID_W   = 4;
   localparam int unsigned DEF_AXI_DATA_W = 32;
   localparam int unsigned DEF_OSTD_DEPTH = 4;
   localparam int unsigned AXI_LEN_W      = 8;

   localparam int unsigned MST_IDX_W  = $clog2(DEF_MST_NUM);
   localparam int unsigned OSTD_PTR_W = $clog2(DEF_OSTD_DEPTH);

   typedef struct packed {
      logic [DEF_AXI_ADDR_W-1:0] addr;
      logic [DEF_AXI_ID_W-1:0]   id;
      logic [AXI_LEN_W-1:0]      len;
   } aw_payload_t;

   typedef struct packed {
      logic [MST_IDX_W-1:0] mst;
`ifdef W_LEN_CHECK_EN
      logic [AXI_LEN_W-1:0] len;
`endif
   } order_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward, wrapping, and
// moves the pointer just past the winner only when a grant is issued.
module rr_arbiter
   import axi_xbar_pkg::*;
#(
   parameter int unsigned  N     = DEF_MST_NUM,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [N-1:0]     i_req,
   input  logic             i_en,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_gnt_idx,
   output logic             o_gnt_vld
);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] w_cand;
   logic             w_found;

   // First requester at or after the pointer wins
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cand  = '0;
      for (int k = 0; k < int'(N); k++) begin
         w_cand = IDX_W'((int'(r_ptr) + k) % int'(N));
         if (!w_found && i_req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
   end

   assign o_gnt_vld = i_en && w_found;
   assign o_gnt_idx = w_idx;

   always_comb begin
      o_gnt = '0;
      if (o_gnt_vld) o_gnt[w_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_ptr <= '0;
      end else if (o_gnt_vld) begin
         r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
      end
   end

endmodule

// File: rtl/axi_w_order_sched.sv
// Per-slave AW arbiter plus W steering in AW grant order.
// Optional W_LEN_CHECK_EN adds a beat counter and the w_len_err pulse.
module axi_w_order_sched
   import axi_xbar_pkg::*;
#(
   parameter int unsigned  MST_NUM    = DEF_MST_NUM,
   parameter int unsigned  AXI_ADDR_W = DEF_AXI_ADDR_W,
   parameter int unsigned  AXI_ID_W   = DEF_AXI_ID_W,
   parameter int unsigned  AXI_DATA_W = DEF_AXI_DATA_W,
   parameter int unsigned  OSTD_DEPTH = DEF_OSTD_DEPTH,
   localparam int unsigned STRB_W     = AXI_DATA_W / 8
) (
   input  logic                          aclk,
   input  logic                          srst,
   input  logic [MST_NUM-1:0]            s_awvalid,
   output logic [MST_NUM-1:0]            s_awready,
   input  logic [MST_NUM*AXI_ADDR_W-1:0] s_awaddr,
   input  logic [MST_NUM*AXI_ID_W-1:0]   s_awid,
   input  logic [MST_NUM*8-1:0]          s_awlen,
   output logic                          m_awvalid,
   input  logic                          m_awready,
   output logic [AXI_ADDR_W-1:0]         m_awaddr,
   output logic [AXI_ID_W-1:0]           m_awid,
   output logic [7:0]                    m_awlen,
   input  logic [MST_NUM-1:0]            s_wvalid,
   output logic [MST_NUM-1:0]            s_wready,
   input  logic [MST_NUM*AXI_DATA_W-1:0] s_wdata,
   input  logic [MST_NUM*STRB_W-1:0]     s_wstrb,
   input  logic [MST_NUM-1:0]            s_wlast,
   output logic                          m_wvalid,
   input  logic                          m_wready,
   output logic [AXI_DATA_W-1:0]         m_wdata,
   output logic [STRB_W-1:0]             m_wstrb,
   output logic                          m_wlast
`ifdef W_LEN_CHECK_EN
   ,output logic                         w_len_err
`endif
);

   localparam int unsigned CNT_W = OSTD_PTR_W + 1;

   aw_payload_t             r_aw;
   logic                    r_m_awvalid;
   aw_payload_t             w_aw_sel;
   logic [MST_NUM-1:0]      w_gnt;
   logic [MST_IDX_W-1:0]    w_gnt_idx;
   logic                    w_gnt_vld;
   logic                    w_aw_load;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   order_entry_t            w_entry;
   order_entry_t            r_fifo [OSTD_DEPTH];
   logic [OSTD_PTR_W-1:0]   r_wr_ptr;
   logic [OSTD_PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]        r_count;
   logic [MST_IDX_W-1:0]    w_head;

   assign w_full    = (r_count == CNT_W'(OSTD_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_aw_load = (!r_m_awvalid || m_awready) && !w_full;

   rr_arbiter #(.N(MST_NUM)) u_arb (
      .clk       (aclk),
      .srst      (srst),
      .i_req     (s_awvalid),
      .i_en      (w_aw_load),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_gnt_vld (w_gnt_vld)
   );

   assign s_awready = w_gnt;
   assign w_push    = w_gnt_vld;

   always_comb begin
      w_aw_sel = '0;
      for (int i = 0; i < int'(MST_NUM); i++) begin
         if (w_gnt_idx == MST_IDX_W'(i)) begin
            w_aw_sel.addr = s_awaddr[i*AXI_ADDR_W +: AXI_ADDR_W];
            w_aw_sel.id   = s_awid[i*AXI_ID_W +: AXI_ID_W];
            w_aw_sel.len  = s_awlen[i*8 +: 8];
         end
      end
   end

   // One-entry AW output register; payload holds while stalled
   always_ff @(posedge aclk) begin
      if (srst) begin
         r_m_awvalid <= 1'b0;
         r_aw        <= '0;
      end else if (w_push) begin
         r_m_awvalid <= 1'b1;
         r_aw        <= w_aw_sel;
      end else if (m_awready) begin
         r_m_awvalid <= 1'b0;
      end
   end

   assign m_awvalid = r_m_awvalid;
   assign m_awaddr  = r_aw.addr;
   assign m_awid    = r_aw.id;
   assign m_awlen   = r_aw.len;

   always_comb begin
      w_entry     = '0;
      w_entry.mst = w_gnt_idx;
`ifdef W_LEN_CHECK_EN
      w_entry.len = w_aw_sel.len;
`endif
   end

   always_ff @(posedge aclk) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_entry;
   end

   always_ff @(posedge aclk) begin
      if (srst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head = r_fifo[r_rd_ptr].mst;

   // W path follows the FIFO head only; nothing passes while empty
   always_comb begin
      m_wvalid = 1'b0;
      m_wdata  = '0;
      m_wstrb  = '0;
      m_wlast  = 1'b0;
      s_wready = '0;
      for (int i = 0; i < int'(MST_NUM); i++) begin
         if (w_head == MST_IDX_W'(i)) begin
            m_wvalid    = !w_empty && s_wvalid[i];
            m_wdata     = s_wdata[i*AXI_DATA_W +: AXI_DATA_W];
            m_wstrb     = s_wstrb[i*STRB_W +: STRB_W];
            m_wlast     = s_wlast[i];
            s_wready[i] = !w_empty && m_wready;
         end
      end
   end

   assign w_pop = m_wvalid && m_wready && m_wlast;

`ifdef W_LEN_CHECK_EN
   logic [7:0] r_beat_cnt;
   logic       r_w_len_err;
   logic       w_w_hs;
   logic [7:0] w_head_len;

   assign w_w_hs     = m_wvalid && m_wready;
   assign w_head_len = r_fifo[r_rd_ptr].len;

   // Beat index of the head burst; wlast must coincide with index == awlen
   always_ff @(posedge aclk) begin
      if (srst) begin
         r_beat_cnt  <= '0;
         r_w_len_err <= 1'b0;
      end else begin
         r_w_len_err <= w_w_hs && ((m_wlast && (r_beat_cnt != w_head_len)) ||
                                   (!m_wlast && (r_beat_cnt == w_head_len)));
         if (w_pop)       r_beat_cnt <= '0;
         else if (w_w_hs) r_beat_cnt <= r_beat_cnt + 1'b1;
      end
   end

   assign w_len_err = r_w_len_err;
`endif

endmodule

// File: tb/tb_axi_w_order_sched.sv
// Directed bench for axi_w_order_sched; len-check cases build only with W_LEN_CHECK_EN.
module tb_axi_w_order_sched;

   localparam int unsigned NM = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned IW = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic             aclk = 1'b0;
   logic             srst;
   logic [NM-1:0]    s_awvalid;
   logic [NM-1:0]    s_awready;
   logic [NM*AW-1:0] s_awaddr;
   logic [NM*IW-1:0] s_awid;
   logic [NM*8-1:0]  s_awlen;
   logic             m_awvalid;
   logic             m_awready;
   logic [AW-1:0]    m_awaddr;
   logic [IW-1:0]    m_awid;
   logic [7:0]       m_awlen;
   logic [NM-1:0]    s_wvalid;
   logic [NM-1:0]    s_wready;
   logic [NM*DW-1:0] s_wdata;
   logic [NM*SW-1:0] s_wstrb;
   logic [NM-1:0]    s_wlast;
   logic             m_wvalid;
   logic             m_wready;
   logic [DW-1:0]    m_wdata;
   logic [SW-1:0]    m_wstrb;
   logic             m_wlast;
`ifdef W_LEN_CHECK_EN
   logic             w_len_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   axi_w_order_sched dut (
      .aclk      (aclk),
      .srst      (srst),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .s_awaddr  (s_awaddr),
      .s_awid    (s_awid),
      .s_awlen   (s_awlen),
      .m_awvalid (m_awvalid),
      .m_awready (m_awready),
      .m_awaddr  (m_awaddr),
      .m_awid    (m_awid),
      .m_awlen   (m_awlen),
      .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_wlast   (s_wlast),
      .m_wvalid  (m_wvalid),
      .m_wready  (m_wready),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .m_wlast   (m_wlast)
`ifdef W_LEN_CHECK_EN
      ,.w_len_err (w_len_err)
`endif
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_len(input int m, input int len);
      s_awlen[m*8 +: 8] = 8'(len);
   endtask

   task automatic set_wdata(input int m, input logic [DW-1:0] d);
      s_wdata[m*DW +: DW] = d;
   endtask

   task automatic do_reset();
      srst      = 1'b1;
      s_awvalid = '0;
      s_wvalid  = '0;
      s_wlast   = '0;
      tick();
      tick();
      srst = 1'b0;
   endtask

   initial begin
      srst = 1'b1;
      m_awready = 1'b0;
      m_wready  = 1'b0;
      for (int i = 0; i < int'(NM); i++) begin
         s_awaddr[i*AW +: AW] = 32'h1000 * 32'(i + 1);
         s_awid[i*IW +: IW]   = IW'(i + 8);
         set_len(i, 0);
         set_wdata(i, 32'hD000_0000 + 32'(i));
         s_wstrb[i*SW +: SW]  = SW'(1 << i);
      end

      // reset state
      do_reset();
      s_wvalid = 4'b1111;
      #1;
      check("rst_awvalid", 64'(m_awvalid), 64'd0);
      check("rst_awaddr",  64'(m_awaddr),  64'd0);
      check("rst_awid",    64'(m_awid),    64'd0);
      check("rst_awready", 64'(s_awready), 64'd0);
      check("rst_wready",  64'(s_wready),  64'd0);
      check("rst_wvalid",  64'(m_wvalid),  64'd0);
      s_wvalid = '0;

      // single burst from master 2, len 3
      m_awready = 1'b1;
      m_wready  = 1'b1;
      set_len(2, 3);
      s_awvalid = 4'b0100;
      #1;
      check("t1_awready", 64'(s_awready), 64'b0100);
      check("t1_awv_pre", 64'(m_awvalid), 64'd0);
      tick();
      s_awvalid = '0;
      #1;
      check("t1_awvalid", 64'(m_awvalid), 64'd1);
      check("t1_awid",    64'(m_awid),    64'hA);
      check("t1_awaddr",  64'(m_awaddr),  64'h3000);
      check("t1_awlen",   64'(m_awlen),   64'd3);
      check("t1_wv_nodata", 64'(m_wvalid), 64'd0);
      check("t1_wready_h",  64'(s_wready), 64'b0100);
      tick();
      check("t1_aw_done", 64'(m_awvalid), 64'd0);
      for (int b = 0; b < 4; b++) begin
         s_wvalid = 4'b0100;
         s_wlast  = (b == 3) ? 4'b0100 : 4'b0000;
         set_wdata(2, 32'hB000_0000 + 32'(b));
         #1;
         check("t1_wvalid", 64'(m_wvalid), 64'd1);
         check("t1_wdata",  64'(m_wdata),  64'hB000_0000 + 64'(b));
         check("t1_wlast",  64'(m_wlast),  (b == 3) ? 64'd1 : 64'd0);
         check("t1_wready", 64'(s_wready), 64'b0100);
         check("t1_wstrb",  64'(m_wstrb),  64'b0100);
         tick();
      end
      #1;
      check("t1_pop_wready", 64'(s_wready), 64'd0);
      check("t1_pop_wvalid", 64'(m_wvalid), 64'd0);
      s_wvalid = '0;
      s_wlast  = '0;
      set_wdata(2, 32'hD000_0002);
      set_len(2, 0);

      // four simultaneous requesters, W order follows grant order
      do_reset();
      s_awvalid = 4'b1111;
      for (int g = 0; g < 4; g++) begin
         #1;
         check("t2_gnt", 64'(s_awready), 64'(1 << g));
         tick();
         s_awvalid[g] = 1'b0;
         #1;
         check("t2_awid", 64'(m_awid), 64'(g + 8));
      end
      s_awvalid = '0;
      s_wvalid  = 4'b1000;
      s_wlast   = 4'b1111;
      #1;
      check("t2_w3_early_wv", 64'(m_wvalid), 64'd0);
      check("t2_w3_early_wr", 64'(s_wready), 64'b0001);
      tick();
      s_wvalid = 4'b1111;
      for (int g = 0; g < 4; g++) begin
         #1;
         check("t2_w_data",  64'(m_wdata),  64'hD000_0000 + 64'(g));
         check("t2_w_valid", 64'(m_wvalid), 64'd1);
         check("t2_w_ready", 64'(s_wready), 64'(1 << g));
         tick();
      end
      #1;
      check("t2_drained", 64'(s_wready), 64'd0);
      s_wvalid  = '0;
      s_awvalid = 4'b0011;
      #1;
      check("t2_rr_0", 64'(s_awready), 64'b0001);
      tick();
      #1;
      check("t2_rr_1", 64'(s_awready), 64'b0010);
      tick();
      s_awvalid = '0;
      s_wvalid  = 4'b0011;
      #1;
      check("t2_rr_w0", 64'(m_wdata), 64'hD000_0000);
      tick();
      #1;
      check("t2_rr_w1", 64'(m_wdata), 64'hD000_0001);
      tick();
      s_wvalid = '0;

      // AW backpressure keeps payload stable and blocks grants
      do_reset();
      m_awready = 1'b0;
      s_awvalid = 4'b0010;
      #1;
      check("t3_gnt1", 64'(s_awready), 64'b0010);
      tick();
      s_awvalid = 4'b1000;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("t3_no_gnt",  64'(s_awready), 64'd0);
         check("t3_awvalid", 64'(m_awvalid), 64'd1);
         check("t3_awaddr",  64'(m_awaddr),  64'h2000);
         tick();
      end
      m_awready = 1'b1;
      #1;
      check("t3_hs_gnt", 64'(s_awready), 64'b1000);
      tick();
      s_awvalid = '0;
      #1;
      check("t3_next_v",    64'(m_awvalid), 64'd1);
      check("t3_next_addr", 64'(m_awaddr),  64'h4000);
      tick();
      check("t3_done", 64'(m_awvalid), 64'd0);

      // order FIFO full stops grants; one pop frees one grant
      do_reset();
      s_awvalid = 4'b1111;
      for (int g = 0; g < 4; g++) begin
         #1;
         check("t4_gnt", 64'(s_awready), 64'(1 << g));
         tick();
      end
      for (int c = 0; c < 2; c++) begin
         #1;
         check("t4_full", 64'(s_awready), 64'd0);
         tick();
      end
      s_wvalid = 4'b0001;
      s_wlast  = 4'b1111;
      #1;
      check("t4_pop_cycle_aw", 64'(s_awready), 64'd0);
      check("t4_pop_wready",   64'(s_wready),  64'b0001);
      tick();
      s_wvalid = '0;
      #1;
      check("t4_one_gnt", 64'(s_awready), 64'b0001);
      tick();
      #1;
      check("t4_full_again", 64'(s_awready), 64'd0);
      s_awvalid = '0;

      // simultaneous push and pop at count 2
      do_reset();
      s_awvalid = 4'b0011;
      tick();
      tick();
      s_awvalid = 4'b0100;
      s_wvalid  = 4'b0001;
      s_wlast   = 4'b1111;
      #1;
      check("t5_push", 64'(s_awready), 64'b0100);
      check("t5_pop",  64'(s_wready),  64'b0001);
      check("t5_d0",   64'(m_wdata),   64'hD000_0000);
      tick();
      s_awvalid = '0;
      s_wvalid  = 4'b0010;
      #1;
      check("t5_d1",  64'(m_wdata),  64'hD000_0001);
      check("t5_wr1", 64'(s_wready), 64'b0010);
      tick();
      s_wvalid = 4'b0100;
      #1;
      check("t5_d2",  64'(m_wdata),  64'hD000_0002);
      check("t5_wr2", 64'(s_wready), 64'b0100);
      tick();
      #1;
      check("t5_empty_wr", 64'(s_wready), 64'd0);
      check("t5_empty_wv", 64'(m_wvalid), 64'd0);
      s_wvalid = '0;
      s_wlast  = '0;

`ifdef W_LEN_CHECK_EN
      // early wlast on a len=1 burst, then a correct len=1 burst
      do_reset();
      set_len(0, 1);
      s_awvalid = 4'b0001;
      tick();
      s_awvalid = '0;
      s_wvalid  = 4'b0001;
      s_wlast   = 4'b0001;
      #1;
      check("lc_err_idle", 64'(w_len_err), 64'd0);
      tick();
      s_wvalid = '0;
      s_wlast  = '0;
      #1;
      check("lc_err_pulse", 64'(w_len_err), 64'd1);
      tick();
      check("lc_err_clear", 64'(w_len_err), 64'd0);
      s_awvalid = 4'b0001;
      tick();
      s_awvalid = '0;
      s_wvalid  = 4'b0001;
      s_wlast   = 4'b0000;
      tick();
      check("lc_ok_b0", 64'(w_len_err), 64'd0);
      s_wlast = 4'b0001;
      tick();
      s_wvalid = '0;
      s_wlast  = '0;
      #1;
      check("lc_ok_b1", 64'(w_len_err), 64'd0);
      tick();
      check("lc_ok_after", 64'(w_len_err), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
